// File: rtl/spi_master_if.sv
// Bus bundle between the SPI master and its user/slave side: frame handshake plus the
// four SPI wires.
interface spi_master_if #(
   parameter int unsigned WIDTH = 40
) ();
   logic             start;
   logic [WIDTH-1:0] d;
   logic             miso;
   logic             sck;
   logic             mosi;
   logic             ss_n;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] q;

   modport master (
      input  start, d, miso,
      output sck, mosi, ss_n, busy, done, q
   );

   modport slave (
      output start, d, miso,
      input  sck, mosi, ss_n, busy, done, q
   );
endinterface

// File: rtl/spi_master.sv
// Mode-0 SPI master: one WIDTH-bit full-duplex frame per accepted start, MSB first,
// sck half-period of DIV clk cycles, all outputs registered.
module spi_master #(
   parameter int unsigned WIDTH = 40,
   parameter int unsigned DIV   = 4
) (
   input logic          clk,
   input logic          reset,
   spi_master_if.master bus
);
   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] DivLast = CW'(DIV - 1);
   localparam logic [BW-1:0] BitLast = BW'(WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StHold} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    div_q, div_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic [WIDTH-1:0] rx_q, rx_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             sck_q, sck_d;
   logic             mosi_q, mosi_d;
   logic             ss_n_q, ss_n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             miso_meta_q, miso_sync_q;
   logic             div_end;
   logic [WIDTH-1:0] rx_shift;

   assign div_end  = (div_q == DivLast);
   assign rx_shift = {rx_q[WIDTH-2:0], miso_sync_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         div_q       <= '0;
         bit_q       <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         q_q         <= '0;
         sck_q       <= 1'b0;
         mosi_q      <= 1'b0;
         ss_n_q      <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         miso_meta_q <= 1'b0;
         miso_sync_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         q_q         <= q_d;
         sck_q       <= sck_d;
         mosi_q      <= mosi_d;
         ss_n_q      <= ss_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         miso_meta_q <= bus.miso;
         miso_sync_q <= miso_meta_q;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q + CW'(1);
      bit_d   = bit_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      q_d     = q_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;
      ss_n_d  = ss_n_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            div_d = '0;
            if (bus.start) begin
               tx_d    = bus.d;
               mosi_d  = bus.d[WIDTH-1];
               ss_n_d  = 1'b0;
               busy_d  = 1'b1;
               bit_d   = '0;
               state_d = StSetup;
            end
         end
         // Both phases end with a rising sck edge, where the slave's bit is captured.
         StSetup, StLow: begin
            if (div_end) begin
               div_d   = '0;
               sck_d   = 1'b1;
               rx_d    = rx_shift;
               state_d = StHigh;
            end
         end
         StHigh: begin
            if (div_end) begin
               div_d = '0;
               sck_d = 1'b0;
               if (bit_q == BitLast) begin
                  state_d = StHold;
               end else begin
                  tx_d    = {tx_q[WIDTH-2:0], 1'b0};
                  mosi_d  = tx_q[WIDTH-2];
                  bit_d   = bit_q + BW'(1);
                  state_d = StLow;
               end
            end
         end
         StHold: begin
            if (div_end) begin
               div_d   = '0;
               ss_n_d  = 1'b1;
               busy_d  = 1'b0;
               q_d     = rx_q;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.sck  = sck_q;
   assign bus.mosi = mosi_q;
   assign bus.ss_n = ss_n_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.q    = q_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback and slave-model frames, ignored starts,
// mid-frame reset, back-to-back frames and a DIV=3 loopback soak.
module tb_spi_master;
   localparam int unsigned W = 40;

   logic clk;
   logic reset;
   logic loop;
   int   checks   = 0;
   int   failures = 0;

   spi_master_if #(.WIDTH(W)) bus ();
   spi_master_if #(.WIDTH(W)) bus3 ();

   spi_master #(.WIDTH(W), .DIV(4)) dut (.clk(clk), .reset(reset), .bus(bus.master));
   spi_master #(.WIDTH(W), .DIV(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.master));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mode-0 slave: shifts mosi in on sck rise, presents slave_word MSB first, advancing on sck fall.
   logic [W-1:0] slave_word;
   logic [W-1:0] slave_rx;
   logic         slave_miso;
   int           rises = 0;
   int           falls = 0;
   int           falls_base;
   int           slave_k;

   always @(posedge bus.sck) begin
      rises    <= rises + 1;
      slave_rx <= {slave_rx[W-2:0], bus.mosi};
   end
   always @(negedge bus.sck) falls <= falls + 1;

   always_comb begin
      slave_k    = falls - falls_base;
      slave_miso = (slave_k >= 0 && slave_k < 40) ? slave_word[39 - slave_k] : 1'b0;
   end

   assign bus.miso  = loop ? bus.mosi : slave_miso;
   assign bus3.miso = bus3.mosi;

   // Phase-length monitor for the DIV=3 instance.
   int   hi_run = 0, lo_run = 0, phase_seen = 0, phase_bad = 0;
   logic prev_sck3 = 1'b0;
   always @(negedge clk) begin
      prev_sck3 <= bus3.sck;
      if (bus3.sck === 1'b1) begin
         hi_run <= hi_run + 1;
         lo_run <= 0;
         if (!prev_sck3) begin
            phase_seen <= phase_seen + 1;
            if (lo_run != 3) phase_bad <= phase_bad + 1;
         end
      end else begin
         hi_run <= 0;
         lo_run <= (bus3.ss_n === 1'b1) ? 0 : lo_run + 1;
         if (prev_sck3) begin
            phase_seen <= phase_seen + 1;
            if (hi_run != 3) phase_bad <= phase_bad + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (bus.done !== 1'b1 && n < budget);
   endtask

   task automatic wait_done3(input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (bus3.done !== 1'b1 && n < budget);
   endtask

   task automatic start_frame(input logic [W-1:0] data);
      bus.d     = data;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) step();
      checks++; if (bus.sck !== 1'b0) begin failures++; $display("FAIL reset_sck: got %b want 0", bus.sck); end
      checks++; if (bus.ss_n !== 1'b1) begin failures++; $display("FAIL reset_ss_n: got %b want 1", bus.ss_n); end
      checks++; if (bus.mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b want 0", bus.mosi); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++; if (bus.q !== 40'h0) begin failures++; $display("FAIL reset_q: got %h want 0", bus.q); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_loopback();
      logic [W-1:0] dv;
      int n, r0;
      dv = 40'hA5_0F_3C_96_E1;
      loop = 1'b1;
      r0 = rises;
      start_frame(dv);
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL lb_busy_start: got %b want 1", bus.busy); end
      checks++; if (bus.ss_n !== 1'b0) begin failures++; $display("FAIL lb_ss_n_start: got %b want 0", bus.ss_n); end
      checks++; if (bus.mosi !== 1'b1) begin failures++; $display("FAIL lb_mosi_first: got %b want 1", bus.mosi); end
      wait_done(400, n);
      checks++; if (n != 324) begin failures++; $display("FAIL lb_latency: got %0d want 324", n); end
      checks++; if (bus.q !== dv) begin failures++; $display("FAIL lb_q: got %h want %h", bus.q, dv); end
      checks++; if (rises - r0 != 40) begin failures++; $display("FAIL lb_rises: got %0d want 40", rises - r0); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL lb_busy_done: got %b want 0", bus.busy); end
      step();
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL lb_done_pulse: got %b want 0", bus.done); end
      checks++; if (bus.q !== dv) begin failures++; $display("FAIL lb_q_hold: got %h want %h", bus.q, dv); end
   endtask

   task automatic test_slave();
      logic [W-1:0] dv;
      int n;
      dv = 40'hC3_5A_F0_0F_69;
      loop = 1'b0;
      slave_word = 40'h12_3456_789A;
      falls_base = falls;
      start_frame(dv);
      wait_done(400, n);
      checks++; if (n != 324) begin failures++; $display("FAIL slv_latency: got %0d want 324", n); end
      checks++; if (slave_rx !== dv) begin failures++; $display("FAIL slv_rx: got %h want %h", slave_rx, dv); end
      checks++; if (bus.q !== 40'h12_3456_789A) begin failures++; $display("FAIL slv_q: got %h want 123456789a", bus.q); end
      loop = 1'b1;
      step();
   endtask

   task automatic test_ignore();
      logic [W-1:0] d1, d2;
      int dones, dn;
      d1 = 40'h55_55AA_AA33;
      d2 = 40'hFF_0000_FFFF;
      dones = 0;
      dn = 0;
      start_frame(d1);
      for (int n = 1; n <= 400; n++) begin
         if (n == 10 || n == 200) begin bus.start = 1'b1; bus.d = d2; end
         if (n == 11 || n == 201) bus.start = 1'b0;
         step();
         if (bus.done === 1'b1) begin dones++; if (dn == 0) dn = n; end
         if (n == 200) begin
            checks++;
            if (bus.q !== 40'h12_3456_789A) begin failures++; $display("FAIL ign_q_hold: got %h want 123456789a", bus.q); end
         end
      end
      checks++; if (dones != 1) begin failures++; $display("FAIL ign_done_count: got %0d want 1", dones); end
      checks++; if (dn != 324) begin failures++; $display("FAIL ign_latency: got %0d want 324", dn); end
      checks++; if (bus.q !== d1) begin failures++; $display("FAIL ign_q: got %h want %h", bus.q, d1); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ign_busy_end: got %b want 0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] dv2;
      int n;
      dv2 = 40'h8F_1E_2D_3C_4B;
      start_frame(40'h3C_C3_96_69_0F);
      repeat (150) step();
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rm_busy_before: got %b want 1", bus.busy); end
      reset = 1'b1;
      #1;
      checks++; if (bus.sck !== 1'b0) begin failures++; $display("FAIL rm_sck: got %b want 0", bus.sck); end
      checks++; if (bus.ss_n !== 1'b1) begin failures++; $display("FAIL rm_ss_n: got %b want 1", bus.ss_n); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rm_busy: got %b want 0", bus.busy); end
      checks++; if (bus.q !== 40'h0) begin failures++; $display("FAIL rm_q: got %h want 0", bus.q); end
      checks++; if (bus.mosi !== 1'b0) begin failures++; $display("FAIL rm_mosi: got %b want 0", bus.mosi); end
      repeat (2) step();
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rm_done: got %b want 0", bus.done); end
      reset = 1'b0;
      start_frame(dv2);
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rm_first_busy: got %b want 1", bus.busy); end
      checks++; if (bus.ss_n !== 1'b0) begin failures++; $display("FAIL rm_first_ss_n: got %b want 0", bus.ss_n); end
      checks++; if (bus.mosi !== 1'b1) begin failures++; $display("FAIL rm_first_mosi: got %b want 1", bus.mosi); end
      wait_done(400, n);
      checks++; if (n != 324) begin failures++; $display("FAIL rm_latency: got %0d want 324", n); end
      checks++; if (bus.q !== dv2) begin failures++; $display("FAIL rm_q_after: got %h want %h", bus.q, dv2); end
      step();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] q1;
      int n, dones, t1, t2, ss_hi;
      n = 0; dones = 0; t1 = 0; t2 = 0; ss_hi = 0; q1 = '0;
      loop = 1'b1;
      bus.d = 40'h00_0000_0001;
      bus.start = 1'b1;
      step();
      while (dones < 2 && n < 800) begin
         step();
         n++;
         if (bus.done === 1'b1) dones++;
         if (bus.ss_n === 1'b1 && dones < 2) ss_hi++;
         if (bus.done === 1'b1 && dones == 1) begin
            t1 = n;
            q1 = bus.q;
            bus.d = 40'h80_0000_0000;
         end
         if (bus.done === 1'b1 && dones == 2) t2 = n;
         if (t1 != 0 && n == t1 + 1) bus.start = 1'b0;
      end
      bus.start = 1'b0;
      checks++; if (t1 != 324) begin failures++; $display("FAIL b2b_first_latency: got %0d want 324", t1); end
      checks++; if (q1 !== 40'h00_0000_0001) begin failures++; $display("FAIL b2b_q1: got %h want 0000000001", q1); end
      checks++; if (ss_hi != 1) begin failures++; $display("FAIL b2b_ss_gap: got %0d want 1", ss_hi); end
      checks++; if (t2 - t1 != 325) begin failures++; $display("FAIL b2b_spacing: got %0d want 325", t2 - t1); end
      checks++; if (bus.q !== 40'h80_0000_0000) begin failures++; $display("FAIL b2b_q2: got %h want 8000000000", bus.q); end
      step();
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_no_third: got %b want 0", bus.busy); end
   endtask

   task automatic test_div3();
      logic [63:0] r;
      logic [W-1:0] dv;
      int n;
      for (int f = 0; f < 150; f++) begin
         r = {$urandom(), $urandom()};
         dv = r[W-1:0];
         bus3.d = dv;
         bus3.start = 1'b1;
         step();
         bus3.start = 1'b0;
         wait_done3(300, n);
         checks++; if (n != 243) begin failures++; $display("FAIL d3_latency f%0d: got %0d want 243", f, n); end
         checks++; if (bus3.q !== dv) begin failures++; $display("FAIL d3_q f%0d: got %h want %h", f, bus3.q, dv); end
         step();
      end
      checks++; if (phase_bad != 0) begin failures++; $display("FAIL d3_phase_len: got %0d bad want 0", phase_bad); end
      checks++; if (phase_seen != 12000) begin failures++; $display("FAIL d3_phase_count: got %0d want 12000", phase_seen); end
   endtask

   initial begin
      reset      = 1'b1;
      loop       = 1'b1;
      bus.start  = 1'b0;
      bus.d      = '0;
      bus3.start = 1'b0;
      bus3.d     = '0;
      slave_word = '0;
      falls_base = 0;
      test_reset();
      test_loopback();
      test_slave();
      test_ignore();
      test_reset_mid();
      test_back_to_back();
      test_div3();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
